instr_buffer: RTL and testbench

- Circular instruction queue between the fetch second stage (IF1) and decode.
- Accepts 0–4 pre-packed instruction entries per cycle from IF1.
- Presents the two oldest entries to a dual-issue decoder, which retires 0–2 per cycle.
- Reports occupancy back to IF1, which uses it to compute the number of entries it pushes.

---
 rtl/instr_buffer_pkg.sv | 31 +++
 rtl/instr_buffer_ptr_ctrl.sv | 67 ++++++
 rtl/instr_buffer.sv | 66 ++++++
 tb/tb_instr_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/instr_buffer_pkg.sv
// ---------------------------------------------------------------------------
// instr_buffer_pkg
//   Shared constants and types for the IF1 -> decode instruction buffer.
//   Holds the buffer geometry (depth, entry width, push/pop widths), the
//   field offsets of a packed entry {pc_valid, pc_is_jump, pc, inst}, and
//   a small helper that turns the decoder's pop request into a legal amount.
// ---------------------------------------------------------------------------
package instr_buffer_pkg;

    localparam int IB_WIDTH_LOG2  = 4;
    localparam int IB_DATA_BUS_WD = 66;
    localparam int DEPTH          = 1 << IB_WIDTH_LOG2;
    localparam int PUSH_W         = 4;
    localparam int POP_W          = 2;

    // Field offsets inside one packed entry
    localparam int INST_LSB  = 0;
    localparam int PC_LSB    = 32;
    localparam int JUMP_BIT  = 64;
    localparam int VALID_BIT = 65;

    typedef logic [IB_WIDTH_LOG2-1:0]  ib_ptr_t;
    typedef logic [IB_WIDTH_LOG2:0]    ib_cnt_t;
    typedef logic [IB_DATA_BUS_WD-1:0] ib_entry_t;

    // The decoder can retire at most two entries; an encoded 3 is treated as 2.
    function automatic logic [1:0] clampPop(input logic [1:0] popNum);
        return (popNum == 2'd3) ? 2'd2 : popNum;
    endfunction

endpackage

// File: rtl/instr_buffer_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// instr_buffer_ptr_ctrl
//   Head/tail/count bookkeeping for the instruction buffer.
//   Ports:
//     clk, rst, flush_IB : clock, synchronous reset and flush (both clear)
//     i_pushNum          : lanes offered by IF1 this cycle (0..4, >4 dropped)
//     i_popNum           : entries the decoder consumes (0..2, 3 means 2)
//     o_head, o_tail     : read / write pointers, wrapping mod DEPTH
//     o_count            : current occupancy, 0..DEPTH
//     o_pushWrEn         : the whole push is accepted and storage may be written
// ---------------------------------------------------------------------------
module instr_buffer_ptr_ctrl
    import instr_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_IB,
    input  logic [2:0] i_pushNum,
    input  logic [1:0] i_popNum,
    output ib_ptr_t    o_head,
    output ib_ptr_t    o_tail,
    output ib_cnt_t    o_count,
    output logic       o_pushWrEn
);

    ib_ptr_t    r_head;
    ib_ptr_t    r_tail;
    ib_cnt_t    r_count;

    logic       w_clear;
    ib_cnt_t    w_free;
    logic       w_pushOk;
    logic [2:0] w_pushAmt;
    logic [1:0] w_popReq;
    logic [1:0] w_popAmt;

    // Free space is measured before this cycle's pop, so an accepted push can
    // never land on a slot that is still being read out this cycle.
    always_comb begin
        w_clear   = rst | flush_IB;
        w_free    = ib_cnt_t'(DEPTH) - r_count;
        w_pushOk  = (i_pushNum <= 3'd4) && (ib_cnt_t'(i_pushNum) <= w_free);
        w_pushAmt = w_pushOk ? i_pushNum : 3'd0;
        w_popReq  = clampPop(i_popNum);
        // count is below 2 whenever it is smaller than the request, so its
        // low two bits are the whole value there
        w_popAmt  = (ib_cnt_t'(w_popReq) > r_count) ? r_count[1:0] : w_popReq;
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + ib_ptr_t'(w_popAmt);
            r_tail  <= r_tail + ib_ptr_t'(w_pushAmt);
            r_count <= r_count + ib_cnt_t'(w_pushAmt) - ib_cnt_t'(w_popAmt);
        end
    end

    assign o_head     = r_head;
    assign o_tail     = r_tail;
    assign o_count    = r_count;
    assign o_pushWrEn = w_pushOk & ~w_clear;

endmodule

// File: rtl/instr_buffer.sv
// ---------------------------------------------------------------------------
// instr_buffer
//   Circular instruction queue between IF1 and a dual-issue decoder.
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     flush_IB       : discard all contents (same effect as reset)
//     if1_to_ib      : up to four packed entries, lane 0 oldest
//     push_num       : number of valid push lanes
//     can_push_size  : occupancy count reported back to IF1
//     ib_to_id       : two oldest entries, lane 0 = head
//     ib_valid       : ib_valid[i] set when more than i entries are held
//     pop_num        : entries consumed by decode this cycle
// ---------------------------------------------------------------------------
module instr_buffer
    import instr_buffer_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_IB,
    input  logic [PUSH_W-1:0][IB_DATA_BUS_WD-1:0] if1_to_ib,
    input  logic [2:0]                           push_num,
    output logic [IB_WIDTH_LOG2:0]               can_push_size,
    output logic [POP_W-1:0][IB_DATA_BUS_WD-1:0]  ib_to_id,
    output logic [POP_W-1:0]                     ib_valid,
    input  logic [1:0]                           pop_num
);

    ib_entry_t r_mem [DEPTH];

    ib_ptr_t   w_head;
    ib_ptr_t   w_tail;
    ib_cnt_t   w_count;
    logic      w_pushWrEn;

    instr_buffer_ptr_ctrl u_ptrCtrl (
        .clk        (clk),
        .rst        (rst),
        .flush_IB   (flush_IB),
        .i_pushNum  (push_num),
        .i_popNum   (pop_num),
        .o_head     (w_head),
        .o_tail     (w_tail),
        .o_count    (w_count),
        .o_pushWrEn (w_pushWrEn)
    );

    // Storage is never cleared; validity is tracked purely by count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_W; k++) begin
            if (w_pushWrEn && (3'(k) < push_num)) begin
                r_mem[w_tail + ib_ptr_t'(k)] <= if1_to_ib[k];
            end
        end
    end

    // Reads come straight from storage with no write bypass, giving a
    // one-cycle push-to-visible latency.
    always_comb begin
        ib_to_id[0]   = r_mem[w_head];
        ib_to_id[1]   = r_mem[w_head + ib_ptr_t'(1)];
        ib_valid[0]   = (w_count > ib_cnt_t'(0));
        ib_valid[1]   = (w_count > ib_cnt_t'(1));
        can_push_size = w_count;
    end

endmodule

// File: tb/tb_instr_buffer.sv
// ---------------------------------------------------------------------------
// tb_instr_buffer
//   Directed plus randomized bench for instr_buffer. A queue model holds the
//   entries the buffer should contain, oldest first.
// ---------------------------------------------------------------------------
module tb_instr_buffer;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_IB = 1'b0;
    logic [3:0][65:0]  if1_to_ib = '0;
    logic [2:0]        push_num = '0;
    logic [4:0]        can_push_size;
    logic [1:0][65:0]  ib_to_id;
    logic [1:0]        ib_valid;
    logic [1:0]        pop_num = '0;

    int          total = 0;
    int          bad = 0;
    logic [65:0] model [$];
    logic [31:0] nextPc = 32'h1c000000;

    instr_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .flush_IB      (flush_IB),
        .if1_to_ib     (if1_to_ib),
        .push_num      (push_num),
        .can_push_size (can_push_size),
        .ib_to_id      (ib_to_id),
        .ib_valid      (ib_valid),
        .pop_num       (pop_num)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // One compared value with a tag
    task automatic checkVal(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all visible outputs against the queue model
    task automatic checkOutput(input string tag);
        int sz;
        sz = model.size();
        checkVal({tag, ".count"}, 66'(can_push_size), 66'(sz));
        checkVal({tag, ".valid"}, 66'(ib_valid), 66'({sz > 1, sz > 0}));
        if (sz > 0) checkVal({tag, ".lane0"}, ib_to_id[0], model[0]);
        if (sz > 1) checkVal({tag, ".lane1"}, ib_to_id[1], model[1]);
    endtask

    // Drive one cycle of inputs, advance the model at the clock edge,
    // then return the inputs to idle just after the edge.
    task automatic applyStimulus(input int pushN, input int popN, input bit fl, input bit rs);
        logic [3:0][65:0] lanes;
        int sz, popReq, eff;
        bit accept;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            lanes[k] = {1'($urandom), 1'($urandom), nextPc + 32'(4 * k), 32'($urandom)};
        end
        if1_to_ib = lanes;
        push_num  = 3'(pushN);
        pop_num   = 2'(popN);
        flush_IB  = fl;
        rst       = rs;
        @(posedge clk);
        if (rs || fl) begin
            model.delete();
        end else begin
            sz     = model.size();
            accept = (pushN <= 4) && (pushN <= 16 - sz);
            popReq = (popN == 3) ? 2 : popN;
            eff    = (popReq < sz) ? popReq : sz;
            for (int i = 0; i < eff; i++) void'(model.pop_front());
            if (accept) begin
                for (int k = 0; k < pushN; k++) model.push_back(lanes[k]);
                nextPc = nextPc + 32'(4 * pushN);
            end
        end
        #1;
        push_num = '0;
        pop_num  = '0;
        flush_IB = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        int pn, pp;
        bit fl;

        // Reset then a first push of four entries
        applyStimulus(0, 0, 0, 1);
        checkOutput("reset");
        checkVal("reset.count", 66'(can_push_size), 66'd0);
        checkVal("reset.valid", 66'(ib_valid), 66'd0);
        applyStimulus(4, 0, 0, 0);
        checkOutput("push4");
        checkVal("push4.count", 66'(can_push_size), 66'd4);
        checkVal("push4.valid", 66'(ib_valid), 66'b11);
        checkVal("push4.pc0", 66'(ib_to_id[0][63:32]), 66'h1c000000);
        checkVal("push4.pc1", 66'(ib_to_id[1][63:32]), 66'h1c000004);

        // Fill to full then drain two per cycle
        applyStimulus(0, 0, 0, 1);
        applyStimulus(4, 0, 0, 0);
        applyStimulus(4, 0, 0, 0);
        applyStimulus(4, 0, 0, 0);
        applyStimulus(3, 0, 0, 0);
        checkVal("fill.count15", 66'(can_push_size), 66'd15);
        applyStimulus(1, 0, 0, 0);
        checkOutput("fill16");
        checkVal("fill.count16", 66'(can_push_size), 66'd16);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 2, 0, 0);
            checkOutput("drain");
            checkVal("drain.count", 66'(can_push_size), 66'(14 - 2 * i));
        end

        // Steady push 2 / pop 2 across the wrap point
        applyStimulus(4, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2, 2, 0, 0);
            checkOutput("wrap");
            checkVal("wrap.count", 66'(can_push_size), 66'd4);
        end

        // Simultaneous push and pop: the old third entry becomes the head
        applyStimulus(0, 0, 0, 1);
        applyStimulus(3, 0, 0, 0);
        applyStimulus(4, 2, 0, 0);
        checkOutput("pushpop");
        checkVal("pushpop.count", 66'(can_push_size), 66'd5);
        checkVal("pushpop.head", 66'(ib_to_id[0][63:32]), 66'(nextPc - 32'd20));

        // Flush wins over a concurrent push and pop
        applyStimulus(0, 0, 0, 1);
        applyStimulus(4, 0, 0, 0);
        applyStimulus(4, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkVal("flush.pre", 66'(can_push_size), 66'd9);
        applyStimulus(4, 2, 1, 0);
        checkOutput("flush");
        checkVal("flush.count", 66'(can_push_size), 66'd0);
        checkVal("flush.valid", 66'(ib_valid), 66'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("afterflush");
        checkVal("afterflush.count", 66'(can_push_size), 66'd1);

        // Overfull push is dropped; over-pop clamps to the count
        applyStimulus(0, 0, 0, 1);
        applyStimulus(4, 0, 0, 0);
        applyStimulus(4, 0, 0, 0);
        applyStimulus(4, 0, 0, 0);
        applyStimulus(2, 0, 0, 0);
        applyStimulus(4, 0, 0, 0);
        checkOutput("overfull");
        checkVal("overfull.count", 66'(can_push_size), 66'd14);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 2, 0, 0);
        checkOutput("overpop");
        checkVal("overpop.count", 66'(can_push_size), 66'd0);

        // Randomized traffic including illegal push/pop encodings and flushes
        for (int i = 0; i < 400; i++) begin
            pn = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            pp = int'($urandom_range(0, 3));
            fl = ($urandom_range(0, 39) == 0);
            applyStimulus(pn, pp, fl, 0);
            checkOutput("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
